// File: rtl/obstacle_pool_pkg.sv
// Shared constants and helpers for the obstacle pool.
package obstacle_pool_pkg;

    localparam int unsigned NUM_OBS_TYPES = 6;
    localparam int unsigned FULL_X_W      = 10;
    localparam int unsigned GAP_W         = 8;

    // Visible screen width in down-shifted position units.
    function automatic int unsigned screen_w(input int unsigned conv);
        return 640 >> conv;
    endfunction

    // Fold a 3-bit random value onto the NUM_OBS_TYPES obstacle types.
    function automatic logic [2:0] fold_type(input logic [2:0] r);
        return (r >= 3'(NUM_OBS_TYPES)) ? r - 3'(NUM_OBS_TYPES) : r;
    endfunction

endpackage

// File: rtl/obstacle_pool_alloc.sv
// Lowest-index free-slot priority encoder.
module obstacle_pool_alloc
    import obstacle_pool_pkg::*;
#(
    parameter int unsigned NUM_OBS = 4
) (
    input  logic [NUM_OBS-1:0] free_mask,
    output logic [NUM_OBS-1:0] grant,
    output logic               any_free
);

    // Isolate the lowest set bit of the free mask.
    always_comb begin
        grant    = free_mask & (~free_mask + NUM_OBS'(1));
        any_free = |free_mask;
    end

endmodule

// File: rtl/obstacle_pool.sv
// Obstacle pool: NUM_OBS slots that scroll left every game tick, with new
// obstacles spawned from the LFSR after a randomised gap.
// Optional feature: define OBSTACLE_POOL_SPEEDUP_EN to raise the scroll speed
// every SPEEDUP_SPAWNS spawns, up to SPEED_MAX.
module obstacle_pool
    import obstacle_pool_pkg::*;
#(
    parameter int unsigned NUM_OBS        = 4,
    parameter int unsigned CONV           = 2,
    parameter int unsigned MIN_GAP        = 40,
    parameter int unsigned GAP_RAND_W     = 5,
    parameter int unsigned SPEED_INIT     = 1,
    parameter int unsigned SPEED_MAX      = 4,
    parameter int unsigned SPEEDUP_SPAWNS = 8,
    localparam int unsigned PW            = FULL_X_W - CONV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  game_tick,
    input  logic                  game_start,
    input  logic                  game_frozen,
    input  logic [7:0]            rng,
    output logic [NUM_OBS*PW-1:0] obs_pos,
    output logic [NUM_OBS*3-1:0]  obs_type,
    output logic [NUM_OBS-1:0]    obs_valid,
    output logic [2:0]            speed
);

    localparam logic [PW-1:0] OFFSCREEN = '1;
    localparam logic [PW-1:0] SPAWN_X   = PW'(screen_w(CONV) - 1);
    // One extra bit so MIN_GAP plus the random offset cannot wrap.
    localparam int unsigned   TGT_W     = GAP_W + 1;

    logic [NUM_OBS-1:0][PW-1:0] pos_q, pos_d, moved_pos;
    logic [NUM_OBS-1:0][2:0]    type_q, type_d, moved_type;
    logic [NUM_OBS-1:0]         valid_q, valid_d, moved_valid;
    logic [GAP_W-1:0]           gap_cnt_q, gap_cnt_d, gap_acc;
    logic [GAP_W:0]             gap_sum;
    logic [TGT_W-1:0]           gap_target_q, gap_target_d;
    logic [NUM_OBS-1:0]         grant;
    logic                       any_free;
    logic                       tick_en;
    logic                       spawn;
    logic [2:0]                 cur_speed;
    logic                       unused_rng;

    assign unused_rng = ^rng;

    obstacle_pool_alloc #(
        .NUM_OBS (NUM_OBS)
    ) u_alloc (
        .free_mask (~moved_valid),
        .grant     (grant),
        .any_free  (any_free)
    );

    // Move step: scroll valid slots, retiring those that would pass x=0.
    always_comb begin
        moved_pos   = pos_q;
        moved_type  = type_q;
        moved_valid = valid_q;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (valid_q[i]) begin
                if (pos_q[i] >= PW'(cur_speed)) begin
                    moved_pos[i] = pos_q[i] - PW'(cur_speed);
                end else begin
                    moved_valid[i] = 1'b0;
                    moved_pos[i]   = OFFSCREEN;
                    moved_type[i]  = 3'd0;
                end
            end
        end
    end

    // Gap accumulation and spawn decision.
    always_comb begin
        tick_en = game_tick && !game_frozen && !game_start;
        gap_sum = {1'b0, gap_cnt_q} + (GAP_W + 1)'(cur_speed);
        gap_acc = gap_sum[GAP_W] ? '1 : gap_sum[GAP_W-1:0];
        spawn   = tick_en && ({1'b0, gap_acc} >= gap_target_q) && any_free;
    end

    // Slot and gap next-state.
    always_comb begin
        pos_d        = pos_q;
        type_d       = type_q;
        valid_d      = valid_q;
        gap_cnt_d    = gap_cnt_q;
        gap_target_d = gap_target_q;
        if (game_start) begin
            pos_d        = '1;
            type_d       = '0;
            valid_d      = '0;
            gap_cnt_d    = '0;
            gap_target_d = TGT_W'(MIN_GAP);
        end else if (tick_en) begin
            pos_d     = moved_pos;
            type_d    = moved_type;
            valid_d   = moved_valid;
            gap_cnt_d = gap_acc;
            if (spawn) begin
                for (int i = 0; i < NUM_OBS; i++) begin
                    if (grant[i]) begin
                        pos_d[i]   = SPAWN_X;
                        type_d[i]  = fold_type(rng[2:0]);
                        valid_d[i] = 1'b1;
                    end
                end
                gap_cnt_d    = '0;
                gap_target_d = TGT_W'(MIN_GAP) + TGT_W'(rng[GAP_RAND_W-1:0]);
            end
        end
    end

    // Slot and gap state registers; pos resets to all ones (offscreen).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q        <= '1;
            type_q       <= '0;
            valid_q      <= '0;
            gap_cnt_q    <= '0;
            gap_target_q <= TGT_W'(MIN_GAP);
        end else begin
            pos_q        <= pos_d;
            type_q       <= type_d;
            valid_q      <= valid_d;
            gap_cnt_q    <= gap_cnt_d;
            gap_target_q <= gap_target_d;
        end
    end

`ifdef OBSTACLE_POOL_SPEEDUP_EN
    localparam int unsigned SCNT_W = $clog2(SPEEDUP_SPAWNS + 1);

    logic [2:0]        speed_q, speed_d;
    logic [SCNT_W-1:0] spawn_cnt_q, spawn_cnt_d;

    // Count spawns and bump the speed every SPEEDUP_SPAWNS of them.
    always_comb begin
        speed_d     = speed_q;
        spawn_cnt_d = spawn_cnt_q;
        if (game_start) begin
            speed_d     = 3'(SPEED_INIT);
            spawn_cnt_d = '0;
        end else if (spawn) begin
            if (spawn_cnt_q == SCNT_W'(SPEEDUP_SPAWNS - 1)) begin
                spawn_cnt_d = '0;
                if (speed_q < 3'(SPEED_MAX)) begin
                    speed_d = speed_q + 3'd1;
                end
            end else begin
                spawn_cnt_d = spawn_cnt_q + SCNT_W'(1);
            end
        end
    end

    // Speed and spawn counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            speed_q     <= 3'(SPEED_INIT);
            spawn_cnt_q <= '0;
        end else begin
            speed_q     <= speed_d;
            spawn_cnt_q <= spawn_cnt_d;
        end
    end

    assign cur_speed = speed_q;
`else
    logic unused_cfg;

    assign unused_cfg = (SPEED_MAX != 0) ^ (SPEEDUP_SPAWNS != 0);
    assign cur_speed  = 3'(SPEED_INIT);
`endif

    assign obs_pos   = pos_q;
    assign obs_type  = type_q;
    assign obs_valid = valid_q;
    assign speed     = cur_speed;

endmodule

// File: tb/tb_obstacle_pool.sv
// Bench for obstacle_pool: a default instance (a) and a MIN_GAP=1 instance (b)
// share one set of inputs and are checked against a behavioural model.
module tb_obstacle_pool;

    localparam int NOBS = 4;
    localparam int PW   = 8;

    logic clk = 1'b0;
    logic rst_n, game_tick, game_start, game_frozen;
    logic [7:0] rng;
    logic [NOBS*PW-1:0] pos_a, pos_b;
    logic [NOBS*3-1:0]  type_a, type_b;
    logic [NOBS-1:0]    valid_a, valid_b;
    logic [2:0]         speed_a, speed_b;

    always #5 clk = ~clk;

    obstacle_pool u_dut_a (
        .clk (clk), .rst_n (rst_n), .game_tick (game_tick), .game_start (game_start),
        .game_frozen (game_frozen), .rng (rng), .obs_pos (pos_a), .obs_type (type_a),
        .obs_valid (valid_a), .speed (speed_a)
    );

    obstacle_pool #(.MIN_GAP (1), .GAP_RAND_W (2)) u_dut_b (
        .clk (clk), .rst_n (rst_n), .game_tick (game_tick), .game_start (game_start),
        .game_frozen (game_frozen), .rng (rng), .obs_pos (pos_b), .obs_type (type_b),
        .obs_valid (valid_b), .speed (speed_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, one set per instance.
    int mg [2] = '{40, 1};
    int rw [2] = '{5, 2};
    int m_pos [2][NOBS];
    int m_type [2][NOBS];
    bit m_valid [2][NOBS];
    int m_speed [2];
    int m_gap [2];
    int m_tgt [2];
    int m_scnt [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input int m, input bit rn, input bit st, input bit tk,
                              input bit fr, input logic [7:0] r);
        int slot;
        if (!rn || st) begin
            for (int i = 0; i < NOBS; i++) begin
                m_valid[m][i] = 0; m_pos[m][i] = 255; m_type[m][i] = 0;
            end
            m_speed[m] = 1; m_gap[m] = 0; m_tgt[m] = mg[m]; m_scnt[m] = 0;
        end else if (!fr && tk) begin
            for (int i = 0; i < NOBS; i++) begin
                if (m_valid[m][i]) begin
                    if (m_pos[m][i] >= m_speed[m]) m_pos[m][i] -= m_speed[m];
                    else begin
                        m_valid[m][i] = 0; m_pos[m][i] = 255; m_type[m][i] = 0;
                    end
                end
            end
            m_gap[m] = (m_gap[m] + m_speed[m] > 255) ? 255 : m_gap[m] + m_speed[m];
            slot = -1;
            for (int i = NOBS - 1; i >= 0; i--) if (!m_valid[m][i]) slot = i;
            if (m_gap[m] >= m_tgt[m] && slot >= 0) begin
                m_valid[m][slot] = 1;
                m_pos[m][slot]   = 159;
                m_type[m][slot]  = (r % 8 >= 6) ? r % 8 - 6 : r % 8;
                m_gap[m]  = 0;
                m_tgt[m]  = mg[m] + (r % (1 << rw[m]));
                m_scnt[m] = m_scnt[m] + 1;
`ifdef OBSTACLE_POOL_SPEEDUP_EN
                if (m_scnt[m] == 8) begin
                    m_scnt[m]  = 0;
                    m_speed[m] = (m_speed[m] < 4) ? m_speed[m] + 1 : 4;
                end
`endif
            end
        end
    endtask

    task automatic model_check(input int m);
        logic [NOBS*PW-1:0] ep;
        logic [NOBS*3-1:0]  et;
        logic [NOBS-1:0]    ev;
        for (int i = 0; i < NOBS; i++) begin
            ep[i*PW +: PW] = PW'(m_pos[m][i]);
            et[i*3 +: 3]   = 3'(m_type[m][i]);
            ev[i]          = m_valid[m][i];
        end
        if (m == 0) begin
            check("model_pos_a", 64'(pos_a), 64'(ep));
            check("model_type_a", 64'(type_a), 64'(et));
            check("model_valid_a", 64'(valid_a), 64'(ev));
            check("model_speed_a", 64'(speed_a), 64'(m_speed[0]));
        end else begin
            check("model_pos_b", 64'(pos_b), 64'(ep));
            check("model_type_b", 64'(type_b), 64'(et));
            check("model_valid_b", 64'(valid_b), 64'(ev));
            check("model_speed_b", 64'(speed_b), 64'(m_speed[1]));
        end
    endtask

    // Drive one cycle of inputs, advance both models on the edge, settle.
    task automatic cycle(input bit rn, input bit st, input bit tk, input bit fr,
                         input logic [7:0] r);
        rst_n = rn; game_start = st; game_tick = tk; game_frozen = fr; rng = r;
        @(posedge clk);
        model_step(0, rn, st, tk, fr, r);
        model_step(1, rn, st, tk, fr, r);
        #1;
    endtask

    typedef struct {
        bit         start;
        bit         frozen;
        int         ticks;
        logic [7:0] rng;
        logic [3:0] exp_valid;
        int         exp_pos0;
        int         exp_pos1;
        int         exp_type0;
    } vec_t;

    vec_t vecs [10];

    initial begin
        bit fr;
        vecs[0] = '{0, 0, 0,   8'h00, 4'b0000, 255, 255, 0};
        vecs[1] = '{1, 0, 39,  8'h1F, 4'b0000, 255, 255, 0};
        vecs[2] = '{0, 0, 1,   8'h1F, 4'b0001, 159, 255, 1};
        vecs[3] = '{0, 0, 1,   8'h1F, 4'b0001, 158, 255, 1};
        vecs[4] = '{0, 0, 69,  8'h1F, 4'b0001, 89,  255, 1};
        vecs[5] = '{0, 0, 1,   8'h1F, 4'b0011, 88,  159, 1};
        vecs[6] = '{0, 1, 100, 8'h1F, 4'b0011, 88,  159, 1};
        vecs[7] = '{1, 1, 0,   8'h1F, 4'b0000, 255, 255, 0};
        vecs[8] = '{1, 0, 40,  8'h07, 4'b0001, 159, 255, 1};
        vecs[9] = '{1, 0, 40,  8'h03, 4'b0001, 159, 255, 3};

        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Directed vectors on instance a; both instances also track the model.
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].start) cycle(1'b1, 1'b1, 1'b0, vecs[v].frozen, vecs[v].rng);
            for (int k = 0; k < vecs[v].ticks; k++)
                cycle(1'b1, 1'b0, 1'b1, vecs[v].frozen, vecs[v].rng);
            cycle(1'b1, 1'b0, 1'b0, vecs[v].frozen, vecs[v].rng);
            check($sformatf("vec%0d_valid", v), 64'(valid_a), 64'(vecs[v].exp_valid));
            check($sformatf("vec%0d_pos0", v), 64'(pos_a[7:0]), 64'(vecs[v].exp_pos0));
            check($sformatf("vec%0d_pos1", v), 64'(pos_a[15:8]), 64'(vecs[v].exp_pos1));
            check($sformatf("vec%0d_type0", v), 64'(type_a[2:0]), 64'(vecs[v].exp_type0));
            check($sformatf("vec%0d_speed", v), 64'(speed_a), 64'd1);
            model_check(0);
            model_check(1);
        end

        // Pool full on instance b: fills in 4 ticks, then spawns are deferred
        // until slot 0 retires and is refilled on the same tick.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check("full_valid", 64'(valid_b), 64'hF);
        check("full_pos0", 64'(pos_b[7:0]), 64'd156);
        for (int k = 0; k < 156; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check("deferred_valid", 64'(valid_b), 64'hF);
        check("deferred_pos0", 64'(pos_b[7:0]), 64'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check("respawn_valid", 64'(valid_b), 64'hF);
        check("respawn_pos0", 64'(pos_b[7:0]), 64'd159);
        check("respawn_pos1", 64'(pos_b[15:8]), 64'd0);
        model_check(1);
        // Start and tick together: only the clear happens.
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        check("start_tick_valid", 64'(valid_b), 64'h0);
        check("start_tick_pos", 64'(pos_b), 64'hFFFF_FFFF);

        // Randomised run against the model.
        fr = 0;
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(39) == 0) fr = ~fr;
            cycle($urandom_range(2999) != 0, $urandom_range(1499) == 0,
                  1'($urandom_range(1)), fr, 8'($urandom));
            model_check(0);
            model_check(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obstacle_pool.md
# obstacle_pool

Parametrised obstacle manager replacing the fixed two-obstacle generator. It keeps a pool of NUM_OBS obstacle slots and spawns new obstacles from the shared LFSR, with a randomised minimum spacing between them. Every active obstacle scrolls left at a common speed on each game tick. It sits between the player controller (start/frozen) and the per-obstacle renderers, and feeds one `obs_render`/`obs_rom` pair per slot.

## Interface
Parameters:
- NUM_OBS, 4: number of slots (2..8).
- CONV, 2: coordinate down-shift; positions are 10-CONV bits (PW).
- MIN_GAP, 40: minimum scrolled distance between spawns, in position units.
- GAP_RAND_W, 5: number of rng LSBs added to MIN_GAP for the next spawn target.
- SPEED_INIT, 1: scroll speed after game start (units/tick).
- SPEED_MAX, 4: speed ceiling (used only with SPEEDUP).
- SPEEDUP_SPAWNS, 8: spawns per speed increment (used only with SPEEDUP).

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset. Synchronous, active-low.
- game_tick, in, 1: one-cycle movement strobe (60 Hz).
- game_start, in, 1: one-cycle pulse that clears the pool.
- game_frozen, in, 1: level; holds all state.
- rng, in, 8: LFSR value.
- obs_pos, out, NUM_OBS*PW: slot i occupies bits [i*PW +: PW].
- obs_type, out, NUM_OBS*3: slot i type, bits [i*3 +: 3].
- obs_valid, out, NUM_OBS: slot occupied.
- speed, out, 3: current scroll speed.

## Operation
- Constants: SCREEN_W = 640>>CONV; SPAWN_X = SCREEN_W-1; OFFSCREEN = all ones (PW bits).
- Reset or game_start sets:
  - all obs_valid=0, obs_pos=OFFSCREEN, obs_type=0;
  - speed=SPEED_INIT; gap_cnt=0; gap_target=MIN_GAP; spawn_cnt=0.
- Priority: rst_n low > game_start > game_frozen > game_tick. While frozen, ticks are ignored and all registers hold.
- Each unfrozen tick performs, in a single cycle:
  1. Move: each valid slot with pos >= speed gets pos -= speed. A valid slot with pos < speed retires: valid=0, pos=OFFSCREEN.
  2. Gap: gap_cnt += speed, saturating at 255 (8 bits).
  3. Spawn:
     - Condition: gap_cnt (new value) >= gap_target and at least one slot is free after step 1. Slots freed in step 1 count as free.
     - Choose the lowest-index free slot. Set valid=1, pos=SPAWN_X.
     - Type: rng[2:0] if below 6, else rng[2:0]-6.
     - gap_cnt=0; gap_target = MIN_GAP + rng[GAP_RAND_W-1:0]; spawn_cnt += 1.
     - A newly spawned slot does not move on its spawn tick.
- Pool full: the spawn is deferred. gap_cnt keeps accumulating (saturating), and the spawn fires on the first tick that has a free slot.
- Invalid slots always output pos=OFFSCREEN and type=0.

## Timing
- All outputs are registered and update on the clock edge that samples game_tick (or game_start/reset) high. Latency is 1 cycle, with no combinational path from input to output.
- game_start and game_tick in the same cycle: only the clear happens.
- Reset mid-game has the same effect as game_start; the first edge with rst_n low clears everything.
- rng is sampled only on the spawn cycle.

## Configuration
- OBSTACLE_POOL_SPEEDUP_EN defined: on a spawn that brings spawn_cnt to SPEEDUP_SPAWNS, speed increments by 1 (saturating at SPEED_MAX) and spawn_cnt resets to 0. The new speed applies from the next tick.
- Not defined: speed stays at SPEED_INIT. The spawn_cnt logic is removed, and SPEED_MAX and SPEEDUP_SPAWNS are unused.

## Structure
- Shared package/header `obstacle_pool_pkg`: SCREEN_W derivation, OFFSCREEN, NUM_OBS_TYPES=6, type-fold function.
- Sub-module `obstacle_pool_alloc`: combinational lowest-index free-slot priority encoder (free mask in; one-hot grant and any_free out).
- Top-level integration: replace the two fixed obstacle wires with NUM_OBS render/ROM instances generated by a loop, OR-ing the colours.

## Test plan
- Reset, then idle: obs_valid=0000, every obs_pos=255 (CONV=2), speed=1.
- game_start, then 40 ticks at speed 1: slot 0 spawns on tick 40 with pos=159. On tick 41 pos=158.
- rng=8'h1F at the first spawn: the next spawn occurs exactly 71 ticks later, into slot 1. rng=8'h07 gives type 1.
- Pool full with MIN_GAP=1: 4 slots fill, and further spawns are deferred. When slot 0 retires (pos 0 < speed), slot 0 is respawned with pos=159 on that same tick.
- game_frozen high for 100 ticks: all outputs unchanged. game_start during frozen: the pool clears immediately.
- With OBSTACLE_POOL_SPEEDUP_EN: speed goes 1→2 after the 8th spawn and saturates at 4 after 24 spawns. Without the macro, speed stays at 1.
